// File: rtl/mult_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler_pkg
// Shared definitions for the round-robin multiplier scheduler:
//   - FSM state encoding (IDLE / CALC / RESP)
//   - default values for the requester count, operand width and index width
//   - modulo-increment helper used for the round-robin pointer
// No ports (package).
// -----------------------------------------------------------------------------
package mult_rr_scheduler_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;
    localparam int IDW_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // (v + 1) mod n for 0 <= v < n, without a divider
    function automatic int wrap_inc(input int v, input int n);
        int r;
        if (v + 1 >= n) begin
            r = 0;
        end else begin
            r = v + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler_if
// Bundles the requester operand ports and the single response port.
//   req_valid/req_ready : per-requester valid/ready handshake (NREQ bits)
//   req_a/req_b         : packed per-requester operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_y        : requester index and unsigned 2*W-bit product
//   busy                : scheduler is not idle
// master = operand sources + response consumer, slave = scheduler.
// -----------------------------------------------------------------------------
interface mult_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_y;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, busy
    );
endinterface

// File: rtl/carry_save_multiplier.sv
// -----------------------------------------------------------------------------
// carry_save_multiplier
// Combinational unsigned W x W -> 2*W multiplier. Partial products are folded
// into a redundant sum/carry pair by a chain of 3:2 compressors; a single
// carry-propagate add resolves the pair at the end.
//   a, b : W-bit unsigned operands
//   p    : 2*W-bit unsigned product
// -----------------------------------------------------------------------------
module carry_save_multiplier #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] sum_s;
    logic [2*W-1:0] carry_s;

    // carry-save reduction of the partial-product rows
    always_comb begin
        logic [2*W-1:0] pp;
        logic [2*W-1:0] nsum;
        logic [2*W-1:0] ncarry;
        sum_s   = {(2*W){1'b0}};
        carry_s = {(2*W){1'b0}};
        pp      = {(2*W){1'b0}};
        nsum    = {(2*W){1'b0}};
        ncarry  = {(2*W){1'b0}};
        for (int i = 0; i < W; i++) begin
            pp      = ({{W{1'b0}}, a} & {(2*W){b[i]}}) << i;
            nsum    = sum_s ^ carry_s ^ pp;
            // the running total always fits in 2*W bits, so the carry shifted
            // out of the top never carries weight
            ncarry  = ((sum_s & carry_s) | (sum_s & pp) | (carry_s & pp)) << 1;
            sum_s   = nsum;
            carry_s = ncarry;
        end
    end

    assign p = sum_s + carry_s;

endmodule

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Picks the first valid requester
// searching rr_ptr, rr_ptr+1, ... modulo NREQ.
//   req_valid : NREQ request bits
//   rr_ptr    : highest-priority requester index
//   grant     : one-hot grant (all zero when nothing is requested)
//   grant_idx : binary index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    logic [NREQ-1:0]   one_s;
    logic              found_s;

    // requests rotated so bit 0 is the current priority holder
    assign dbl_s = {req_valid, req_valid};
    assign rot_s = NREQ'(dbl_s >> rr_ptr);
    assign one_s = {{(NREQ-1){1'b0}}, 1'b1};

    // first set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        found_s   = 1'b0;
        grant_idx = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s   = 1'b1;
                grant_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // one-hot form of the selected index
    always_comb begin
        if (found_s) begin
            grant = one_s << grant_idx;
        end else begin
            grant = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler
// Time-shares one carry_save_multiplier among NREQ requesters. In IDLE a
// round-robin arbiter grants one pending request; its operands are captured,
// multiplied in CALC and the product is presented on the response port in
// RESP until accepted. The round-robin pointer moves past the served
// requester only when its response completes.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : mult_rr_scheduler_if.slave (request ports, response port, busy)
// -----------------------------------------------------------------------------
module mult_rr_scheduler
    import mult_rr_scheduler_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_rr_scheduler_if.slave    bus
);

    state_e          state_q,     state_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]  gid_q,       gid_d;
    logic [W-1:0]    op_a_q,      op_a_d;
    logic [W-1:0]    op_b_q,      op_b_d;
    logic [2*W-1:0]  rsp_y_q,     rsp_y_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q,      busy_d;

    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  grant_idx_s;
    logic            any_valid_s;
    logic [W-1:0]    sel_a_s;
    logic [W-1:0]    sel_b_s;
    logic [2*W-1:0]  product_s;
    logic [NREQ-1:0] req_ready_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    carry_save_multiplier #(
        .W (W)
    ) u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (product_s)
    );

    assign any_valid_s = |grant_s;

    // AND-OR mux of the granted requester's operands
    always_comb begin
        sel_a_s = {W{1'b0}};
        sel_b_s = {W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = sel_a_s | (bus.req_a[i*W +: W] & {W{grant_s[i]}});
            sel_b_s = sel_b_s | (bus.req_b[i*W +: W] & {W{grant_s[i]}});
        end
    end

    // accept strobe: only in IDLE, and forced low while reset is held
    always_comb begin
        if (!rst && (state_q == ST_IDLE)) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // next-state and datapath update
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gid_d       = gid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    op_a_d  = sel_a_s;
                    op_b_d  = sel_b_s;
                    gid_d   = grant_idx_s;
                    state_d = ST_CALC;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_CALC: begin
                rsp_y_d     = product_s;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
                busy_d      = 1'b1;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = IDW'(wrap_inc(int'(gid_q), NREQ));
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                end else begin
                    state_d     = ST_RESP;
                    busy_d      = 1'b1;
                end
            end
            default: begin
                // unreachable encoding: recover to a clean idle
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // state, operand and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {IDW{1'b0}};
            gid_q       <= {IDW{1'b0}};
            op_a_q      <= {W{1'b0}};
            op_b_q      <= {W{1'b0}};
            rsp_y_q     <= {(2*W){1'b0}};
            rsp_id_q    <= {IDW{1'b0}};
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gid_q       <= gid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mult_rr_scheduler
// Self-checking bench: a transaction-level model (pending job + its age in
// cycles, a round-robin pointer) predicts every output each cycle; directed
// scenarios add literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_mult_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic clk;
    logic rst;

    mult_rr_scheduler_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    mult_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // model state: pointer, whether a job is in flight, and its age in cycles
    int   m_ptr  = 0;
    bit   m_have = 1'b0;
    int   m_age  = 0;
    int   m_id   = 0;
    int   m_a    = 0;
    int   m_b    = 0;

    // completed responses as observed on the DUT port: {id, y}
    logic [15:0] rsp_log[$];
    logic [3:0]  hold_mask = 4'b0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_ready(input logic [3:0] v, input int p);
        logic [3:0] r;
        r = 4'b0000;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (v[(p + k) % NREQ]) r = 4'b0000 | (4'b0001 << ((p + k) % NREQ));
        end
        return r;
    endfunction

    function automatic int opnd(input logic [15:0] bus_v, input int i);
        return int'((bus_v >> (i * W)) & 16'h000F);
    endfunction

    // per-cycle comparison against the model, then model advance for the coming edge
    initial begin
        logic [3:0] g;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", 32'(bus.req_ready), 32'd0);
                chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
                chk("rst_busy",  32'(bus.busy),      32'd0);
                chk("rst_y",     32'(bus.rsp_y),     32'd0);
                chk("rst_id",    32'(bus.rsp_id),    32'd0);
                m_ptr = 0; m_have = 1'b0; m_age = 0;
            end else if (!m_have) begin
                g = exp_ready(bus.req_valid, m_ptr);
                chk("idle_ready", 32'(bus.req_ready), 32'(g));
                chk("idle_valid", 32'(bus.rsp_valid), 32'd0);
                chk("idle_busy",  32'(bus.busy),      32'd0);
                if (g != 4'b0000) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (g[i]) begin
                            m_id = i;
                            m_a  = opnd(bus.req_a, i);
                            m_b  = opnd(bus.req_b, i);
                        end
                    end
                    m_have = 1'b1;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                chk("calc_ready", 32'(bus.req_ready), 32'd0);
                chk("calc_valid", 32'(bus.rsp_valid), 32'd0);
                chk("calc_busy",  32'(bus.busy),      32'd1);
                m_age = 2;
            end else begin
                chk("resp_ready", 32'(bus.req_ready), 32'd0);
                chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("resp_busy",  32'(bus.busy),      32'd1);
                chk("resp_y",     32'(bus.rsp_y),     32'(m_a * m_b));
                chk("resp_id",    32'(bus.rsp_id),    32'(m_id));
                if (bus.rsp_ready) begin
                    m_have = 1'b0;
                    m_ptr  = (m_id + 1) % NREQ;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && !rst)
                rsp_log.push_back({6'd0, bus.rsp_id, bus.rsp_y});
        end
    end

    // one clock per step; requests accepted this cycle drop valid unless held
    task automatic run_cycles(input int n);
        logic [3:0] rr;
        repeat (n) begin
            @(negedge clk);
            rr = bus.req_ready;
            @(posedge clk);
            #1;
            bus.req_valid = bus.req_valid & (~rr | hold_mask);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        bus.req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_a     = 16'h0000;
        bus.req_b     = 16'h0000;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset / idle: everything quiet for 5 cycles
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle5_y",     32'(bus.rsp_y),     32'd0);
            chk("idle5_id",    32'(bus.rsp_id),    32'd0);
            chk("idle5_busy",  32'(bus.busy),      32'd0);
            chk("idle5_ready", 32'(bus.req_ready), 32'd0);
        end

        // single request and latency: 0xA * 0x3 = 0x1E
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        set_op(0, 4'hA, 4'h3);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("lat_ready_T", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1 bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("lat_calc_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.rsp_valid), 32'd1);
        chk("lat_y",     32'(bus.rsp_y),     32'h1E);
        chk("lat_id",    32'(bus.rsp_id),    32'd0);
        @(negedge clk);
        chk("lat_done_busy", 32'(bus.busy), 32'd0);

        // round robin from pointer 0
        do_reset();
        rsp_log.delete();
        set_op(0, 4'h5, 4'h7); set_op(1, 4'h3, 4'h9);
        set_op(2, 4'hF, 4'hF); set_op(3, 4'h0, 4'h0);
        bus.req_valid = 4'b1111;
        run_cycles(16);
        set_op(0, 4'h6, 4'h6);
        bus.req_valid = 4'b0001;
        run_cycles(6);
        chk("rr_count", 32'(rsp_log.size()), 32'd5);
        chk("rr_0", 32'(rsp_log[0]), 32'h0023);
        chk("rr_1", 32'(rsp_log[1]), 32'h011B);
        chk("rr_2", 32'(rsp_log[2]), 32'h02E1);
        chk("rr_3", 32'(rsp_log[3]), 32'h0300);
        chk("rr_4", 32'(rsp_log[4]), 32'h0024);

        // fairness: req 1 held, req 3 raised during req 1's first service
        do_reset();
        rsp_log.delete();
        set_op(1, 4'h2, 4'h3); set_op(3, 4'h4, 4'h5);
        hold_mask = 4'b0010;
        bus.req_valid = 4'b0010;
        run_cycles(2);
        bus.req_valid[3] = 1'b1;
        run_cycles(10);
        hold_mask = 4'b0000;
        bus.req_valid[1] = 1'b0;
        run_cycles(8);
        chk("fair_0", 32'(rsp_log[0]), 32'h0106);
        chk("fair_1", 32'(rsp_log[1]), 32'h0314);
        chk("fair_2", 32'(rsp_log[2]), 32'h0106);

        // backpressure: response held 6 cycles with rsp_ready low
        do_reset();
        rsp_log.delete();
        bus.rsp_ready = 1'b0;
        set_op(2, 4'h7, 4'h9);
        bus.req_valid = 4'b0100;
        run_cycles(1);
        set_op(0, 4'h1, 4'h2);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_y",     32'(bus.rsp_y),     32'd63);
            chk("bp_id",    32'(bus.rsp_id),    32'd2);
            chk("bp_busy",  32'(bus.busy),      32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_after_busy",  32'(bus.busy),      32'd0);
        chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_after_ready", 32'(bus.req_ready), 32'h1);
        chk("bp_log", 32'(rsp_log[0]), 32'h023F);
        run_cycles(6);

        // reset during CALC drops the job; next grant starts from pointer 0
        do_reset();
        set_op(2, 4'hF, 4'h2);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("mid_grant", 32'(bus.req_ready), 32'h4);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        rsp_log.delete();
        rst = 1'b1;
        #1;
        chk("mid_valid_async", 32'(bus.rsp_valid), 32'd0);
        chk("mid_busy_async",  32'(bus.busy),      32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_op(1, 4'h3, 4'h3); set_op(3, 4'h2, 4'h2);
        bus.req_valid = 4'b1010;
        run_cycles(10);
        chk("mid_count", 32'(rsp_log.size()), 32'd2);
        chk("mid_0", 32'(rsp_log[0]), 32'h0109);
        chk("mid_1", 32'(rsp_log[1]), 32'h0304);

        // randomized traffic, backpressure, drops and occasional resets
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] rr;
            @(negedge clk);
            rr = bus.req_ready;
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
            end
            bus.req_valid = bus.req_valid & ~rr;
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && ($urandom_range(0, 3) == 0)) begin
                    bus.req_valid[i] = 1'b1;
                    set_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end else if (bus.req_valid[i] && ($urandom_range(0, 15) == 0)) begin
                    bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    set_op(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
